wallace_pipe_reducer: RTL and testbench
=======================================

// Module: wallace_pipe_reducer
// PURPOSE
// - Pipelined, parametrised carry-save (Wallace) reducer: sums NUM_PP pre-shifted partial products to one OUT_W result.
// - Next generation of the multiplier back-end tree: configurable operand count, width and pipeline depth.
// - Adds valid/ready flow control with per-stage bubble collapse.
// - Sits between the Booth partial-product generator and the mantissa normaliser.
// PARAMETERS
// - NUM_PP           13  number of partial products, >= 3
// - PP_W             49  partial-product and internal datapath width
// - OUT_W            48  result width; must be <= PP_W
// - LEVELS_PER_STAGE 2   3:2 compressor levels between pipeline registers, >= 1
// PORTS
// - clk        in   1            single clock, rising edge
// - rst        in   1            asynchronous, active-high reset
// - in_valid   in   1            pp/in_clr hold a valid operand set
// - in_ready   out  1            reducer accepts the set this cycle
// - pp         in   NUM_PP*PP_W  partial products, pp[i*PP_W +: PP_W] = operand i
// - in_clr     in   1            accumulator-restart sideband (used only with WALLACE_ACC_EN)
// - out_valid  out  1            sum is valid
// - out_ready  in   1            downstream accepts sum this cycle
// - sum        out  OUT_W        reduced result
// BEHAVIOUR
// - Reset (async, rst=1): all stage valids 0, all data/sideband registers 0, accumulator 0; sum=0, out_valid=0, in_ready=1 after release.
// - Arithmetic: unsigned, modulo 2^PP_W. Each level groups operands in threes into 3:2 compressors;
//   leftover 1-2 operands pass through. Carry vectors shifted left by 1; bit PP_W dropped.
// - Level count L: iterate n -> 2*floor(n/3) + (n mod 3) until n==2. Default NUM_PP=13 gives L=5.
// - Pipeline: register after every LEVELS_PER_STAGE levels and after level L: S=ceil(L/LEVELS_PER_STAGE) CSA stages.
//   Final stage: carry-propagate add of sum/carry pair into the output register.
// - Latency: S+1 cycles from accepted input to out_valid (default 4), with no stall.
// - sum = low OUT_W bits of output register.
// - Flow control, per stage k (k=0 first CSA stage, k=S output register):
//   ld[k] = !v[k] | ld[k+1], with ld[S] = !out_valid | out_ready; in_ready = ld[0].
//   Combinational ready chain, no skid buffer.
// - Stage k loads data from stage k-1 (stage 0 from pp) when ld[k].
//   v[k] <= v[k-1] (stage 0: in_valid).
//   When !ld[k], stage k holds data and valid unchanged.
// - Bubbles collapse: a stalled full output lets earlier empty stages keep filling; total capacity S+1 sets (default 4).
// - in_clr travels with its operand set through every stage.
// - Simultaneous output handshake and new arrival: output register takes the new result same edge; no lost or duplicated result.
// - Order strictly preserved. in_valid without in_ready: set not taken; source must hold it.
// - Reset mid-operation: all in-flight sets discarded, none emitted after release.
// - Elaboration error if OUT_W > PP_W, NUM_PP < 3 or LEVELS_PER_STAGE < 1.
// CONFIGURATION
// - WALLACE_ACC_EN defined:
//   - output register is a running accumulator; on load, acc <= (clr ? 0 : acc) + T mod 2^PP_W.
//   - T = tree total; clr = that set's in_clr. sum shows acc.
//   - acc updates only when the output stage loads a valid set.
// - WALLACE_ACC_EN undefined:
//   - output register <= T; in_clr ignored; no accumulator.
//   - sideband pipeline bits removed; ports unchanged.
// TESTING (defaults unless stated)
// - T1 latency: pp0=1, pp12=2, others 0, one in_valid pulse, out_ready=1 -> out_valid exactly 4 cycles later, sum=48'h3.
// - T2 wrap: all 13 pp = 49'h1_FFFF_FFFF_FFFF -> sum=48'hFFFF_FFFF_FFF3.
// - T3 streaming: 8 random sets back-to-back, out_ready=1 -> in_ready stays 1; 8 results on consecutive cycles, in order, match model.
// - T4 backpressure:
//   - out_ready=0, offer 6 sets -> exactly 4 accepted, then in_ready=0.
//   - raise out_ready -> 4 results, then remaining 2 accepted; all 6 correct, in order.
// - T5 reset mid-flight: 3 sets in pipe, pulse rst for 1 cycle between edges -> out_valid=0, sum=0 immediately; no output after release until new input.
// - T6 accumulate: sets pp0=5 clr=1, pp0=7 clr=0, pp0=1 clr=0, others 0.
//   - with WALLACE_ACC_EN -> sums 5, 12, 13.
//   - without -> 5, 7, 1.

Source files
------------

// File: rtl/wallace_pipe_reducer_if.sv
// Handshake bundle between the partial-product source, the Wallace reducer and its consumer.
interface wallace_pipe_reducer_if #(
    parameter int unsigned NUM_PP = 13,
    parameter int unsigned PP_W   = 49,
    parameter int unsigned OUT_W  = 48
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_PP*PP_W-1:0] pp;
    logic                   in_clr;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       sum;

    modport master (output in_valid, pp, in_clr, out_ready,
                    input  in_ready, out_valid, sum);
    modport slave  (input  in_valid, pp, in_clr, out_ready,
                    output in_ready, out_valid, sum);
endinterface

// File: rtl/wallace_pipe_reducer.sv
// Pipelined carry-save (Wallace) reducer of NUM_PP partial products with valid/ready flow control.
// Build option WALLACE_ACC_EN turns the output register into a running accumulator cleared by in_clr.
module wallace_pipe_reducer #(
    parameter int unsigned NUM_PP           = 13,
    parameter int unsigned PP_W             = 49,
    parameter int unsigned OUT_W            = 48,
    parameter int unsigned LEVELS_PER_STAGE = 2
) (
    input logic                   clk,
    input logic                   rst,
    wallace_pipe_reducer_if.slave rdc
);

    function automatic int unsigned step_n(input int unsigned n);
        return (n > 2) ? 2 * (n / 3) + (n % 3) : n;
    endfunction

    function automatic int unsigned count_after(input int unsigned n, input int unsigned lv);
        int unsigned c;
        c = n;
        for (int unsigned i = 0; i < lv; i++) c = step_n(c);
        return c;
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned c;
        int unsigned l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = step_n(c);
            l++;
        end
        return l;
    endfunction

    localparam int unsigned LEVELS = num_levels(NUM_PP);
    localparam int unsigned LPS    = (LEVELS_PER_STAGE < 1) ? 1 : LEVELS_PER_STAGE;
    localparam int unsigned STAGES = (LEVELS + LPS - 1) / LPS;

    typedef logic [PP_W-1:0] word_t;

    if (OUT_W > PP_W) begin : g_err_out_w
        $error("wallace_pipe_reducer: OUT_W must not exceed PP_W");
    end
    if (NUM_PP < 3) begin : g_err_num_pp
        $error("wallace_pipe_reducer: NUM_PP must be at least 3");
    end
    if (LEVELS_PER_STAGE < 1) begin : g_err_lps
        $error("wallace_pipe_reducer: LEVELS_PER_STAGE must be at least 1");
    end

    word_t            stg_d [STAGES][NUM_PP];
    word_t            stg_q [STAGES][NUM_PP];
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic [STAGES:0]  v_q;
    logic [STAGES:0]  ld_c;
    logic [STAGES:0]  vin_c;
    logic [STAGES:0]  en_c;

    // A stage may load when it or any stage downstream of it is empty, or the sink drains.
    always_comb begin
        ld_c = '0;
        for (int k = 0; k <= int'(STAGES); k++) begin
            ld_c[k] = rdc.out_ready || (((~v_q) >> k) != '0);
        end
    end

    assign vin_c = {v_q[STAGES-1:0], rdc.in_valid};
    assign en_c  = ld_c & vin_c;

    // Compressor levels of each stage; unused operand slots are tied to zero.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned N_IN  = count_after(NUM_PP, s * LPS);
        localparam int unsigned LV    = (LEVELS - s * LPS < LPS) ? (LEVELS - s * LPS) : LPS;
        localparam int unsigned N_OUT = count_after(N_IN, LV);

        word_t lvl [LV+1][N_IN];

        for (genvar k = 0; k < N_IN; k++) begin : g_src
            if (s == 0) begin : g_pp
                assign lvl[0][k] = rdc.pp[k*PP_W +: PP_W];
            end else begin : g_reg
                assign lvl[0][k] = stg_q[s-1][k];
            end
        end

        for (genvar l = 0; l < LV; l++) begin : g_lvl
            localparam int unsigned N  = count_after(N_IN, l);
            localparam int unsigned G  = N / 3;
            localparam int unsigned NO = 2 * G + N % 3;

            for (genvar g = 0; g < G; g++) begin : g_csa
                word_t a, b, c;
                assign a = lvl[l][3*g];
                assign b = lvl[l][3*g+1];
                assign c = lvl[l][3*g+2];
                assign lvl[l+1][2*g]   = a ^ b ^ c;
                assign lvl[l+1][2*g+1] = ((a & b) | (a & c) | (b & c)) << 1;
            end
            for (genvar j = 0; j < N % 3; j++) begin : g_pass
                assign lvl[l+1][2*G+j] = lvl[l][3*G+j];
            end
            for (genvar k = NO; k < N_IN; k++) begin : g_zero
                assign lvl[l+1][k] = '0;
            end
        end

        for (genvar k = 0; k < NUM_PP; k++) begin : g_out
            if (k < N_OUT) begin : g_live
                assign stg_d[s][k] = lvl[LV][k];
            end else begin : g_dead
                assign stg_d[s][k] = '0;
            end
        end
    end

`ifdef WALLACE_ACC_EN
    logic [STAGES-1:0] clr_q;

    // Restart flag rides alongside its operand set through the CSA stages.
    always_ff @(posedge clk or posedge rst) begin : p_clr
        if (rst) begin
            clr_q <= '0;
        end else begin
            if (en_c[0]) clr_q[0] <= rdc.in_clr;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (en_c[k]) clr_q[k] <= clr_q[k-1];
            end
        end
    end

    assign out_d = OUT_W'(stg_q[STAGES-1][0] + stg_q[STAGES-1][1])
                 + (clr_q[STAGES-1] ? '0 : out_q);
`else
    assign out_d = OUT_W'(stg_q[STAGES-1][0] + stg_q[STAGES-1][1]);
`endif

    always_ff @(posedge clk or posedge rst) begin : p_valid
        if (rst) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k <= int'(STAGES); k++) begin
                if (ld_c[k]) v_q[k] <= vin_c[k];
            end
        end
    end

    // Data only moves with a valid set so the output holds steady between results.
    always_ff @(posedge clk or posedge rst) begin : p_data
        if (rst) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                for (int k = 0; k < int'(NUM_PP); k++) stg_q[s][k] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (en_c[s]) stg_q[s] <= stg_d[s];
            end
            if (en_c[STAGES]) out_q <= out_d;
        end
    end

    assign rdc.in_ready  = ld_c[0];
    assign rdc.out_valid = v_q[STAGES];
    assign rdc.sum       = out_q;

endmodule

// File: tb/tb_wallace_pipe_reducer.sv
// Self-checking bench for wallace_pipe_reducer: directed cases plus randomized traffic against a sum/accumulate model.
module tb_wallace_pipe_reducer;
    localparam int unsigned NPP = 13;
    localparam int unsigned W   = 49;
    localparam int unsigned OW  = 48;

    typedef logic [W-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wallace_pipe_reducer_if #(.NUM_PP(NPP), .PP_W(W), .OUT_W(OW)) bus ();

    wallace_pipe_reducer #(
        .NUM_PP(NPP), .PP_W(W), .OUT_W(OW), .LEVELS_PER_STAGE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdc(bus)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            n_out    = 0;
    int            n_acc    = 0;
    int            last_acc_cyc = 0;
    word_t         pp_set [NPP];
    bit            cur_clr  = 1'b0;
    word_t         acc_m    = '0;
    logic [OW-1:0] exp_q     [$];
    logic [OW-1:0] out_sum_q [$];
    int            out_cyc_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rand_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return word_t'({$urandom(), $urandom()});
        endcase
    endfunction

    task automatic rand_set();
        for (int i = 0; i < int'(NPP); i++) pp_set[i] = rand_word();
    endtask

    task automatic clear_set();
        for (int i = 0; i < int'(NPP); i++) pp_set[i] = '0;
    endtask

    task automatic drive(input bit v, input bit clr);
        bus.in_valid = v;
        bus.in_clr   = clr;
        cur_clr      = clr;
        for (int i = 0; i < int'(NPP); i++) bus.pp[i*W +: W] = pp_set[i];
    endtask

    // Reference: plain modular sum of the operand set, optionally accumulated.
    task automatic model_accept();
        word_t t;
        t = '0;
        for (int i = 0; i < int'(NPP); i++) t = t + pp_set[i];
`ifdef WALLACE_ACC_EN
        acc_m = (cur_clr ? '0 : acc_m) + t;
        exp_q.push_back(acc_m[OW-1:0]);
`else
        exp_q.push_back(t[OW-1:0]);
`endif
    endtask

    // Observe the handshakes that the coming rising edge will perform, then advance past it.
    task automatic step();
        bit            fin;
        bit            fout;
        logic [OW-1:0] e;
        @(negedge clk);
        cyc++;
        fin  = bus.in_valid && bus.in_ready;
        fout = bus.out_valid && bus.out_ready;
        check("in_ready", 64'(bus.in_ready),
              (exp_q.size() >= 4 && !bus.out_ready) ? 64'd0 : 64'd1);
        if (exp_q.size() == 0) check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        if (fout) begin
            out_sum_q.push_back(bus.sum);
            out_cyc_q.push_back(cyc);
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(bus.sum), 64'(e));
            end
        end
        if (fin) begin
            model_accept();
            last_acc_cyc = cyc;
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outputs(input int target, input int bound, input string tag);
        int k;
        k = 0;
        while (n_out < target && k < bound) begin
            step();
            k++;
        end
        check({tag, "_count"}, 64'(n_out), 64'(target));
    endtask

    word_t t4_sets [6][NPP];
    bit    t4_clr  [6];

    task automatic offer_t4(input int a0);
        int idx;
        idx = n_acc - a0;
        if (idx < 6) begin
            pp_set = t4_sets[idx];
            drive(1'b1, t4_clr[idx]);
        end else begin
            drive(1'b0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            n0;
        int            a0;
        int            c;
        bit            hold;
        logic [OW-1:0] t6_exp [3];
        int unsigned   t6_val [3];
        bit            t6_clr [3];

        bus.in_valid  = 1'b0;
        bus.in_clr    = 1'b0;
        bus.pp        = '0;
        bus.out_ready = 1'b0;
        clear_set();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // T1 latency
        bus.out_ready = 1'b1;
        clear_set();
        pp_set[0]  = 49'd1;
        pp_set[12] = 49'd2;
        out_sum_q.delete();
        out_cyc_q.delete();
        drive(1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0);
        wait_outputs(n_out + 1, 20, "t1");
        check("t1_latency", 64'(out_cyc_q[0] - last_acc_cyc), 64'd4);
        check("t1_sum", 64'(out_sum_q[0]), 64'h3);

        // T2 modular wrap
        for (int i = 0; i < int'(NPP); i++) pp_set[i] = 49'h1_FFFF_FFFF_FFFF;
        out_sum_q.delete();
        out_cyc_q.delete();
        drive(1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0);
        wait_outputs(n_out + 1, 20, "t2");
        check("t2_sum", 64'(out_sum_q[0]), 64'hFFFF_FFFF_FFF3);

        // T3 streaming
        out_sum_q.delete();
        out_cyc_q.delete();
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            rand_set();
            drive(1'b1, 1'($urandom_range(0, 1)));
            check("t3_in_ready", 64'(bus.in_ready), 64'd1);
            step();
        end
        drive(1'b0, 1'b0);
        wait_outputs(n0 + 8, 30, "t3");
        check("t3_span", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'd7);

        // T4 backpressure and bubble collapse
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < int'(NPP); i++) t4_sets[s][i] = rand_word();
            t4_clr[s] = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b0;
        a0 = n_acc;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            offer_t4(a0);
            step();
        end
        check("t4_accepted_stalled", 64'(n_acc - a0), 64'd4);
        check("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
        check("t4_out_valid_held", 64'(bus.out_valid), 64'd1);
        check("t4_no_output_stalled", 64'(n_out - n0), 64'd0);
        bus.out_ready = 1'b1;
        c = 0;
        while (c < 40 && ((n_acc - a0) < 6 || (n_out - n0) < 6)) begin
            offer_t4(a0);
            step();
            c++;
        end
        drive(1'b0, 1'b0);
        check("t4_accepted_all", 64'(n_acc - a0), 64'd6);
        check("t4_outputs_all", 64'(n_out - n0), 64'd6);

        // T5 reset mid-flight
        for (int i = 0; i < 3; i++) begin
            rand_set();
            drive(1'b1, 1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_sum", 64'(bus.sum), 64'd0);
        #1 rst = 1'b0;
        exp_q.delete();
        acc_m = '0;
        n0 = n_out;
        repeat (10) step();
        check("t5_no_output", 64'(n_out - n0), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);

        // T6 accumulate / restart sideband
        t6_val[0] = 5; t6_val[1] = 7; t6_val[2] = 1;
        t6_clr[0] = 1'b1; t6_clr[1] = 1'b0; t6_clr[2] = 1'b0;
`ifdef WALLACE_ACC_EN
        t6_exp[0] = 48'd5; t6_exp[1] = 48'd12; t6_exp[2] = 48'd13;
`else
        t6_exp[0] = 48'd5; t6_exp[1] = 48'd7;  t6_exp[2] = 48'd1;
`endif
        out_sum_q.delete();
        out_cyc_q.delete();
        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            clear_set();
            pp_set[0] = word_t'(t6_val[i]);
            drive(1'b1, t6_clr[i]);
            step();
        end
        drive(1'b0, 1'b0);
        wait_outputs(n0 + 3, 30, "t6");
        for (int i = 0; i < 3; i++) check($sformatf("t6_sum%0d", i), 64'(out_sum_q[i]), 64'(t6_exp[i]));

        // Randomized traffic with random backpressure
        hold = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!hold) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_set();
                    drive(1'b1, ($urandom_range(0, 3) == 0));
                end else begin
                    drive(1'b0, 1'b0);
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            a0 = n_acc;
            step();
            hold = bus.in_valid && (n_acc == a0);
        end
        drive(1'b0, 1'b0);
        bus.out_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 30) begin
            step();
            c++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
